// File: rtl/nco_freq_meter_if.sv
// nco_freq_meter_if
// Bundles the sample stream feeding the frequency meter and the measurement
// results it returns.
//   sample_valid : qualifies sample (one sample per clk while high)
//   sample       : unsigned sample, mid-scale = 2**(BIT_DEPTH-1)
//   frequency    : measured frequency, Q32.32 Hz
//   freq_valid   : one-clk pulse when frequency updates
//   no_signal    : no valid measurement available / input timed out
//   busy         : divider running
// master = sample source / result consumer, slave = the meter.
interface nco_freq_meter_if #(
  parameter int BIT_DEPTH = 8
);
  logic                 sample_valid;
  logic [BIT_DEPTH-1:0] sample;
  logic [63:0]          frequency;
  logic                 freq_valid;
  logic                 no_signal;
  logic                 busy;

  modport master (
    output sample_valid, sample,
    input  frequency, freq_valid, no_signal, busy
  );

  modport slave (
    input  sample_valid, sample,
    output frequency, freq_valid, no_signal, busy
  );
endinterface

// File: rtl/nco_freq_meter.sv
// nco_freq_meter
// Measures the fundamental frequency of a unipolar sample stream. Rising
// mid-scale crossings (with hysteresis) delimit windows of PERIODS periods;
// the sample count N of each window is turned into a Q32.32 frequency word
// (SAMPLE_RATE*PERIODS/N) by a 64-step restoring divider that runs while the
// next window is already being counted.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   bus   : slave side of nco_freq_meter_if (samples in, results out)
module nco_freq_meter #(
  parameter int BIT_DEPTH   = 8,
  parameter int SAMPLE_RATE = 48000,
  parameter int PERIODS     = 4,
  parameter int HYST        = 4,
  parameter int CNT_WIDTH   = 32
) (
  input  logic            clk,
  input  logic            reset,
  nco_freq_meter_if.slave bus
);

  localparam int HALF = 2 ** (BIT_DEPTH - 1);
  localparam logic [BIT_DEPTH-1:0] ARM_TH  = BIT_DEPTH'(HALF - HYST);
  localparam logic [BIT_DEPTH-1:0] FIRE_TH = BIT_DEPTH'(HALF + HYST);
  localparam int EW = $clog2(PERIODS + 1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(PERIODS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_PRE = CNT_MAX - 1'b1;
  localparam logic [63:0] DIVIDEND =
    {32'(longint'(SAMPLE_RATE) * longint'(PERIODS)), 32'd0};

  // The divider runs alongside COUNT, so it has its own busy flag rather
  // than a DIVIDE state.
  localparam logic [0:0] ST_SYNC  = 1'b0;
  localparam logic [0:0] ST_COUNT = 1'b1;

  logic [0:0]           r_state;
  logic                 r_armed;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [EW-1:0]        r_edges;
  logic                 r_busy;
  logic [5:0]           r_iter;
  logic [63:0]          r_quot;
  logic [CNT_WIDTH-1:0] r_rem;
  logic [CNT_WIDTH-1:0] r_divisor;
  logic [63:0]          r_frequency;
  logic                 r_freqValid;
  logic                 r_noSignal;

  logic                 w_accept;
  logic                 w_edge;
  logic                 w_counting;
  logic                 w_close;
  logic                 w_timeout;
  logic                 w_divStart;
  logic                 w_done;
  logic [CNT_WIDTH:0]   w_remShift;
  logic [CNT_WIDTH:0]   w_remSub;
  logic                 w_ge;

  assign w_accept   = bus.sample_valid;
  assign w_edge     = w_accept & r_armed & (bus.sample >= FIRE_TH);
  assign w_counting = (r_state == ST_COUNT);
  assign w_close    = w_counting & w_edge & (r_edges == LAST_EDGE);
  // The counter would reach its ceiling on this sample: no usable window.
  assign w_timeout  = w_counting & w_accept & ~w_close & (r_cnt == CNT_PRE);
  // A window closing while the divider is still busy is dropped.
  assign w_divStart = w_close & ~r_busy;
  assign w_done     = r_busy & (r_iter == 6'd63);

  assign w_remShift = {r_rem, r_quot[63]};
  assign w_remSub   = w_remShift - {1'b0, r_divisor};
  assign w_ge       = (w_remShift >= {1'b0, r_divisor});

  // Hysteretic crossing detector: arm below HALF-HYST, fire once at or
  // above HALF+HYST, so a flat or gently wobbling input never fires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_armed <= 1'b0;
    end else if (w_accept) begin
      if (bus.sample < ARM_TH) begin
        r_armed <= 1'b1;
      end else if (w_edge) begin
        r_armed <= 1'b0;
      end
    end
  end

  // Window FSM and interval counter. The edge that closes a window also
  // opens the next one, so consecutive windows share boundary edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_SYNC;
      r_cnt   <= '0;
      r_edges <= '0;
    end else begin
      case (r_state)
        ST_SYNC: begin
          if (w_edge) begin
            r_cnt   <= '0;
            r_edges <= '0;
            r_state <= ST_COUNT;
          end
        end
        default: begin
          if (w_close || w_timeout) begin
            r_cnt   <= '0;
            r_edges <= '0;
            if (w_timeout) begin
              r_state <= ST_SYNC;
            end
          end else if (w_accept) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_edge) begin
              r_edges <= r_edges + 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Restoring divider: the dividend shifts out of r_quot MSB-first while
  // quotient bits shift in at the bottom; after 64 steps r_quot holds the
  // floor quotient. Divisor is N = counter + 1 at the closing edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy    <= 1'b0;
      r_iter    <= '0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
    end else if (w_divStart) begin
      r_busy    <= 1'b1;
      r_iter    <= '0;
      r_quot    <= DIVIDEND;
      r_rem     <= '0;
      r_divisor <= r_cnt + 1'b1;
    end else if (r_busy) begin
      r_quot <= {r_quot[62:0], w_ge};
      r_rem  <= w_ge ? w_remSub[CNT_WIDTH-1:0] : w_remShift[CNT_WIDTH-1:0];
      r_iter <= r_iter + 6'd1;
      if (w_done) begin
        r_busy <= 1'b0;
      end
    end
  end

  // Result register. The final quotient bit is taken combinationally so the
  // result lands on the same edge as the last divide step. A finishing
  // division wins over a simultaneous timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frequency <= '0;
      r_freqValid <= 1'b0;
      r_noSignal  <= 1'b1;
    end else begin
      r_freqValid <= w_done;
      if (w_done) begin
        r_frequency <= {r_quot[62:0], w_ge};
        r_noSignal  <= 1'b0;
      end else if (w_timeout) begin
        r_frequency <= '0;
        r_noSignal  <= 1'b1;
      end
    end
  end

  assign bus.frequency  = r_frequency;
  assign bus.freq_valid = r_freqValid;
  assign bus.no_signal  = r_noSignal;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_nco_freq_meter.sv
// tb_nco_freq_meter
// Directed bench for nco_freq_meter with hand-computed expectations.
// CNT_WIDTH is 12 so the counter timeout is reachable in a short run;
// all measured windows (N=400, N=28, N=192) fit comfortably.
module tb_nco_freq_meter;
  localparam int BIT_DEPTH   = 8;
  localparam int SAMPLE_RATE = 48000;
  localparam int PERIODS     = 4;
  localparam int HYST        = 4;
  localparam int CNT_WIDTH   = 12;

  localparam logic [63:0] F480  = 64'h0000_01E0_0000_0000;
  localparam logic [63:0] F6857 = 64'h0000_1AC9_2492_4924;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  nco_freq_meter_if #(.BIT_DEPTH(BIT_DEPTH)) bus ();

  nco_freq_meter #(
    .BIT_DEPTH(BIT_DEPTH), .SAMPLE_RATE(SAMPLE_RATE), .PERIODS(PERIODS),
    .HYST(HYST), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int          checkCount = 0;
  int          failCount = 0;
  longint      cycleCount = 0;
  longint      lastAcceptCycle = 0;
  longint      markCycle = 0;
  int          markIdx = -1;
  int          probeIdx = -1;
  logic        probeNoSignal = 1'b0;
  int          validCount = 0;
  int          busyCount = 0;
  int          firstBusy = 0;
  int          wrongPulses = 0;
  longint      firstValidCycle = 0;
  longint      secondValidCycle = 0;
  logic [63:0] firstFreq = '0;
  logic [63:0] lastFreq = '0;
  logic [63:0] expFreq = '0;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Pulse log, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.busy) busyCount++;
    if (bus.freq_valid) begin
      validCount++;
      if (validCount == 1) begin
        firstValidCycle = cycleCount;
        firstFreq = bus.frequency;
        firstBusy = busyCount;
      end
      if (validCount == 2) secondValidCycle = cycleCount;
      lastFreq = bus.frequency;
      if (bus.frequency != expFreq) wrongPulses++;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearLog();
    validCount = 0;
    busyCount = 0;
    firstBusy = 0;
    wrongPulses = 0;
    firstValidCycle = 0;
    secondValidCycle = 0;
    firstFreq = '0;
    lastFreq = '0;
  endtask

  // One accepted sample, then 'gap' clocks with sample_valid low.
  task automatic applyStimulus(input logic [BIT_DEPTH-1:0] value, input int gap);
    bus.sample_valid = 1'b1;
    bus.sample = value;
    @(posedge clk);
    #1;
    lastAcceptCycle = cycleCount;
    bus.sample_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  // 0/255 square wave: low for the first half of each period, so rising
  // edges fall on sample indices period/2 + k*period.
  task automatic runSquare(input int period, input int firstIdx, input int lastIdx,
                           input int gap);
    for (int i = firstIdx; i <= lastIdx; i++) begin
      applyStimulus(((i % period) < (period / 2)) ? 8'd0 : 8'd255, gap);
      if (i == markIdx) markCycle = lastAcceptCycle;
      if (i == probeIdx) probeNoSignal = bus.no_signal;
    end
  endtask

  task automatic idle(input int n);
    bus.sample_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset();
    bus.sample_valid = 1'b0;
    bus.sample = 8'd128;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] phase;
    bus.sample_valid = 1'b0;
    bus.sample = 8'd128;
    doReset();

    checkOutput("rstFrequency", bus.frequency, 64'd0);
    checkOutput("rstFreqValid", {63'd0, bus.freq_valid}, 64'd0);
    checkOutput("rstNoSignal", {63'd0, bus.no_signal}, 64'd1);
    checkOutput("rstBusy", {63'd0, bus.busy}, 64'd0);

    // Period 100: edges at 50,150,..., 5th edge (index 450) closes N=400.
    // busy covers the 64 clocks after that edge; the pulse sits in the next
    // clock, i.e. it is raised by the 64th clock edge after the closing one.
    clearLog();
    expFreq = F480;
    markIdx = 450;
    probeIdx = 449;
    runSquare(100, 0, 1299, 0);
    idle(100);
    markIdx = -1;
    probeIdx = -1;
    checkOutput("sqLatency", 64'(firstValidCycle - markCycle), 64'd64);
    checkOutput("sqFreq", firstFreq, F480);
    checkOutput("sqBusyLen", 64'(firstBusy), 64'd64);
    checkOutput("sqNoSigBefore", {63'd0, probeNoSignal}, 64'd1);
    checkOutput("sqNoSigAfter", {63'd0, bus.no_signal}, 64'd0);
    checkOutput("sqInterval", 64'(secondValidCycle - firstValidCycle), 64'd400);
    checkOutput("sqHeld", bus.frequency, F480);

    // Period 7: N=28, windows close faster than the divider, so some drop.
    doReset();
    clearLog();
    expFreq = F6857;
    runSquare(7, 0, 559, 0);
    idle(100);
    checkOutput("p7Freq", lastFreq, F6857);
    checkOutput("p7WrongPulses", 64'(wrongPulses), 64'd0);
    checkOutput("p7Repeats", {63'd0, validCount >= 3}, 64'd1);

    // Same wave, one valid sample in three: gaps are not counted.
    doReset();
    clearLog();
    expFreq = F480;
    runSquare(100, 0, 1299, 2);
    idle(100);
    checkOutput("gapFreq", firstFreq, F480);
    checkOutput("gapInterval", 64'(secondValidCycle - firstValidCycle), 64'd1200);
    checkOutput("gapWrongPulses", 64'(wrongPulses), 64'd0);

    // Lock, then wobble inside the hysteresis band until the counter times out.
    doReset();
    clearLog();
    runSquare(100, 0, 999, 0);
    idle(100);
    checkOutput("hystLocked", {63'd0, bus.no_signal}, 64'd0);
    clearLog();
    for (int i = 0; i < 10000; i++) begin
      applyStimulus((i % 2 == 1) ? 8'd131 : 8'd125, 0);
    end
    checkOutput("hystNoSignal", {63'd0, bus.no_signal}, 64'd1);
    checkOutput("hystFreq", bus.frequency, 64'd0);
    checkOutput("hystStateSync", {63'd0, dut.r_state}, 64'd0);
    checkOutput("hystPulses", 64'(validCount), 64'd0);
    clearLog();
    runSquare(100, 0, 999, 0);
    idle(100);
    checkOutput("relockPulse", {63'd0, validCount >= 1}, 64'd1);
    checkOutput("relockFreq", lastFreq, F480);
    checkOutput("relockNoSignal", {63'd0, bus.no_signal}, 64'd0);

    // Reset pulse while the second window's division is in flight.
    doReset();
    clearLog();
    runSquare(100, 0, 860, 0);
    checkOutput("midFreqBefore", bus.frequency, F480);
    checkOutput("midBusyBefore", {63'd0, bus.busy}, 64'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midRstBusy", {63'd0, bus.busy}, 64'd0);
    checkOutput("midRstFreq", bus.frequency, 64'd0);
    checkOutput("midRstNoSignal", {63'd0, bus.no_signal}, 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    clearLog();
    runSquare(100, 0, 448, 0);
    idle(80);
    checkOutput("midNoEarlyPulse", 64'(validCount), 64'd0);
    runSquare(100, 449, 599, 0);
    idle(80);
    checkOutput("midNewWindowPulse", 64'(validCount), 64'd1);
    checkOutput("midNewWindowFreq", lastFreq, F480);

    // Loopback against a 1 kHz square NCO (32-bit phase, inc = 2^32*1000/48000).
    doReset();
    clearLog();
    phase = 32'd0;
    for (int i = 0; i < 1200; i++) begin
      applyStimulus(phase[31] ? 8'd0 : 8'd255, 0);
      phase = phase + 32'd89478485;
    end
    idle(80);
    checkOutput("ncoPulse", {63'd0, validCount >= 1}, 64'd1);
    checkOutput("ncoWithinTol",
                {63'd0, (lastFreq >= (64'd995 << 32)) && (lastFreq <= (64'd1005 << 32))},
                64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
